// File: rtl/load_queue.sv
// -----------------------------------------------------------------------------
// load_queue
//
// Circular, age-ordered queue of address-resolved loads sitting between the
// address unit, the reorder buffer and the data controller. Loads are
// allocated at the tail, marked safe by ROB broadcasts, issued one at a time
// to the data controller and retired from the head once their result has
// been broadcast back to the ROB.
//
// Build option:
//   LQ_OOO_EN  defined   -> the oldest eligible entry (scanning from head)
//                           issues, so younger safe loads may bypass an
//                           unsafe head.
//              undefined -> only the head entry may issue (strict in-order);
//                           the scan logic is not built.
//
// Parameters:
//   DEPTH   queue entries (power of two, >= 2)
//   ADDR_W  address width
//   DATA_W  load data width
//   ROB_W   ROB tag width
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable / hold)
//   au_lq_*      allocation handshake (valid/ready) with addr, dest, funct3
//   rob_lq_*     flush and safe-tag broadcast from the ROB
//   lq_rob_*     result pulse (tag, value) back to the ROB
//   lq_dc_*      memory request (req, addr, one-hot width, signed)
//   dc_lq_*      memory acknowledge pulse with extended data
// -----------------------------------------------------------------------------
module load_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              au_lq_valid_in,
    output logic              au_lq_ready_out,
    input  logic [ADDR_W-1:0] au_lq_addr_in,
    input  logic [ROB_W-1:0]  au_lq_dest_in,
    input  logic [2:0]        au_lq_funct3_in,
    input  logic              rob_lq_flush_in,
    input  logic              rob_lq_safe_en_in,
    input  logic [ROB_W-1:0]  rob_lq_safe_dest_in,
    output logic              lq_rob_en_out,
    output logic [ROB_W-1:0]  lq_rob_dest_out,
    output logic [DATA_W-1:0] lq_rob_value_out,
    output logic              lq_dc_req_out,
    output logic [ADDR_W-1:0] lq_dc_addr_out,
    output logic [2:0]        lq_dc_width_out,
    output logic              lq_dc_signed_out,
    input  logic              dc_lq_ack_in,
    input  logic [DATA_W-1:0] dc_lq_data_in
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } iss_state_t;

    // -------------------------------------------------------------------------
    // funct3 decode helpers
    // -------------------------------------------------------------------------
    function automatic logic [2:0] width_onehot(input logic [2:0] funct3);
        logic [2:0] w;
        case (funct3[1:0])
            2'b00:   w = 3'b001;
            2'b01:   w = 3'b010;
            default: w = 3'b100;
        endcase
        return w;
    endfunction

    // Only LB and LH sign-extend; LW has nothing to extend.
    function automatic logic sign_ext(input logic [2:0] funct3);
        return (funct3[2] == 1'b0) && (funct3[1:0] != 2'b10);
    endfunction

    // -------------------------------------------------------------------------
    // Queue storage and pointers
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [PTR_W-1:0]  count;
    logic [IDX_W-1:0]  head_idx;
    logic [IDX_W-1:0]  tail_idx;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_safe;
    logic [DEPTH-1:0]  ent_issued;
    logic [DEPTH-1:0]  ent_done;
    logic [ADDR_W-1:0] ent_addr   [DEPTH];
    logic [ROB_W-1:0]  ent_dest   [DEPTH];
    logic [2:0]        ent_funct3 [DEPTH];

    // Issue tracking
    iss_state_t        state;
    iss_state_t        state_nxt;
    logic [IDX_W-1:0]  iss_idx;
    logic [DEPTH-1:0]  elig;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              issue_fire;
    logic              ack_fire;

    // Event qualifiers
    logic              flush_fire;
    logic              alloc_fire;
    logic              retire_fire;
    logic              safe_fire;
    logic              alloc_safe;

    // Result stage
    logic              vld_p0;
    logic [ROB_W-1:0]  dest_p0;
    logic [DATA_W-1:0] value_p0;

    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];

    // Pointer MSB acts as a wrap bit, so the modular difference is the
    // occupancy and reaches exactly DEPTH when the queue is full.
    assign count           = tail_ptr - head_ptr;
    assign au_lq_ready_out = (count != PTR_W'(DEPTH));

    assign flush_fire  = rdy_in && rob_lq_flush_in;
    assign safe_fire   = rdy_in && rob_lq_safe_en_in && !rob_lq_flush_in;
    assign alloc_fire  = rdy_in && au_lq_valid_in && au_lq_ready_out && !rob_lq_flush_in;
    assign retire_fire = rdy_in && !rob_lq_flush_in && ent_valid[head_idx] && ent_done[head_idx];

    // A broadcast landing in the allocation cycle of the same tag must not
    // be lost, since the entry is not yet valid in the array to match it.
    assign alloc_safe  = safe_fire && (rob_lq_safe_dest_in == au_lq_dest_in);

    // -------------------------------------------------------------------------
    // Issue selection
    // -------------------------------------------------------------------------
    always_comb begin
        elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = ent_valid[i] & ent_safe[i] & ~ent_issued[i] & ~ent_done[i];
        end
    end

`ifdef LQ_OOO_EN
    logic [IDX_W-1:0] scan_idx;

    // Walk the ring starting at head so the first hit is the oldest
    // eligible load.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = head_idx;
        scan_idx  = head_idx;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + IDX_W'(i);
            if (!sel_found && elig[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end
`else
    assign sel_idx   = head_idx;
    assign sel_found = elig[head_idx];
`endif

    // -------------------------------------------------------------------------
    // Issue FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue_fire = 1'b0;
        ack_fire   = 1'b0;
        if (rdy_in) begin
            if (rob_lq_flush_in) begin
                state_nxt = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sel_found) begin
                            issue_fire = 1'b1;
                            state_nxt  = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (dc_lq_ack_in) begin
                            ack_fire  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Entry control bits and pointers
    // -------------------------------------------------------------------------
    // Within one cycle the indices touched by safe/issue/ack/retire/alloc
    // never collide on the same bit with conflicting values: issue picks a
    // not-done entry, retire a done one, and alloc an invalid slot.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ent_valid  <= '0;
            ent_safe   <= '0;
            ent_issued <= '0;
            ent_done   <= '0;
            head_ptr   <= '0;
            tail_ptr   <= '0;
        end else if (flush_fire) begin
            ent_valid  <= '0;
            ent_safe   <= '0;
            ent_issued <= '0;
            ent_done   <= '0;
            head_ptr   <= '0;
            tail_ptr   <= '0;
        end else if (rdy_in) begin
            if (safe_fire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_valid[i] && !ent_issued[i] &&
                        (ent_dest[i] == rob_lq_safe_dest_in)) begin
                        ent_safe[i] <= 1'b1;
                    end
                end
            end
            if (issue_fire) begin
                ent_issued[sel_idx] <= 1'b1;
            end
            if (ack_fire) begin
                ent_done[iss_idx] <= 1'b1;
            end
            if (retire_fire) begin
                ent_valid[head_idx]  <= 1'b0;
                ent_safe[head_idx]   <= 1'b0;
                ent_issued[head_idx] <= 1'b0;
                ent_done[head_idx]   <= 1'b0;
                head_ptr             <= head_ptr + 1'b1;
            end
            if (alloc_fire) begin
                ent_valid[tail_idx]  <= 1'b1;
                ent_safe[tail_idx]   <= alloc_safe;
                ent_issued[tail_idx] <= 1'b0;
                ent_done[tail_idx]   <= 1'b0;
                tail_ptr             <= tail_ptr + 1'b1;
            end
        end
    end

    // Entry payload carries no reset: it is only read behind a valid bit.
    always_ff @(posedge clk_in) begin
        if (alloc_fire) begin
            ent_addr[tail_idx]   <= au_lq_addr_in;
            ent_dest[tail_idx]   <= au_lq_dest_in;
            ent_funct3[tail_idx] <= au_lq_funct3_in;
        end
    end

    // -------------------------------------------------------------------------
    // Memory request registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lq_dc_req_out    <= 1'b0;
            lq_dc_addr_out   <= '0;
            lq_dc_width_out  <= '0;
            lq_dc_signed_out <= 1'b0;
            iss_idx          <= '0;
        end else if (flush_fire) begin
            lq_dc_req_out    <= 1'b0;
        end else if (rdy_in) begin
            if (issue_fire) begin
                lq_dc_req_out    <= 1'b1;
                lq_dc_addr_out   <= ent_addr[sel_idx];
                lq_dc_width_out  <= width_onehot(ent_funct3[sel_idx]);
                lq_dc_signed_out <= sign_ext(ent_funct3[sel_idx]);
                iss_idx          <= sel_idx;
            end else if (ack_fire) begin
                lq_dc_req_out    <= 1'b0;
            end
        end
    end

    // ---- stage p0: capture acknowledged data ----
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_p0 <= 1'b0;
        end else if (flush_fire) begin
            vld_p0 <= 1'b0;
        end else if (rdy_in) begin
            vld_p0 <= ack_fire;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ack_fire) begin
            dest_p0  <= ent_dest[iss_idx];
            value_p0 <= dc_lq_data_in;
        end
    end

    // ---- stage p1: result broadcast to ROB ----
    // A flush also squashes a result still in flight through p0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lq_rob_en_out    <= 1'b0;
            lq_rob_dest_out  <= '0;
            lq_rob_value_out <= '0;
        end else if (flush_fire) begin
            lq_rob_en_out    <= 1'b0;
        end else if (rdy_in) begin
            lq_rob_en_out <= vld_p0;
            if (vld_p0) begin
                lq_rob_dest_out  <= dest_p0;
                lq_rob_value_out <= value_p0;
            end
        end
    end

endmodule

// File: tb/tb_load_queue.sv
// -----------------------------------------------------------------------------
// tb_load_queue
//
// Directed bench for load_queue instantiated with DEPTH=4. Inputs are driven
// 1 time unit after the rising edge and outputs are sampled at the same
// point, so each step() advances exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_load_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;

    logic              clk_in;
    logic              rst_in;
    logic              rdy_in;
    logic              au_lq_valid_in;
    logic              au_lq_ready_out;
    logic [ADDR_W-1:0] au_lq_addr_in;
    logic [ROB_W-1:0]  au_lq_dest_in;
    logic [2:0]        au_lq_funct3_in;
    logic              rob_lq_flush_in;
    logic              rob_lq_safe_en_in;
    logic [ROB_W-1:0]  rob_lq_safe_dest_in;
    logic              lq_rob_en_out;
    logic [ROB_W-1:0]  lq_rob_dest_out;
    logic [DATA_W-1:0] lq_rob_value_out;
    logic              lq_dc_req_out;
    logic [ADDR_W-1:0] lq_dc_addr_out;
    logic [2:0]        lq_dc_width_out;
    logic              lq_dc_signed_out;
    logic              dc_lq_ack_in;
    logic [DATA_W-1:0] dc_lq_data_in;

    int checks;
    int errors;

    load_queue #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .ROB_W (ROB_W)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .au_lq_valid_in     (au_lq_valid_in),
        .au_lq_ready_out    (au_lq_ready_out),
        .au_lq_addr_in      (au_lq_addr_in),
        .au_lq_dest_in      (au_lq_dest_in),
        .au_lq_funct3_in    (au_lq_funct3_in),
        .rob_lq_flush_in    (rob_lq_flush_in),
        .rob_lq_safe_en_in  (rob_lq_safe_en_in),
        .rob_lq_safe_dest_in(rob_lq_safe_dest_in),
        .lq_rob_en_out      (lq_rob_en_out),
        .lq_rob_dest_out    (lq_rob_dest_out),
        .lq_rob_value_out   (lq_rob_value_out),
        .lq_dc_req_out      (lq_dc_req_out),
        .lq_dc_addr_out     (lq_dc_addr_out),
        .lq_dc_width_out    (lq_dc_width_out),
        .lq_dc_signed_out   (lq_dc_signed_out),
        .dc_lq_ack_in       (dc_lq_ack_in),
        .dc_lq_data_in      (dc_lq_data_in)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full single load on an empty queue: allocate with same-cycle safe,
    // issue, same-cycle ack, result pulse.
    task automatic run_load(input logic [3:0] tag, input logic [31:0] addr,
                            input logic [2:0] f3, input logic [31:0] data,
                            input logic [2:0] exp_w, input logic exp_s);
        check("ready_before_alloc", au_lq_ready_out, 1);
        au_lq_valid_in      = 1'b1;
        au_lq_addr_in       = addr;
        au_lq_dest_in       = tag;
        au_lq_funct3_in     = f3;
        rob_lq_safe_en_in   = 1'b1;
        rob_lq_safe_dest_in = tag;
        step();                               // edge 1: allocate + safe
        au_lq_valid_in      = 1'b0;
        rob_lq_safe_en_in   = 1'b0;
        check("req_low_after_alloc", lq_dc_req_out, 0);
        step();                               // edge 2: issue
        check("req_high", lq_dc_req_out, 1);
        check("req_addr", lq_dc_addr_out, addr);
        check("req_width", lq_dc_width_out, exp_w);
        check("req_signed", lq_dc_signed_out, exp_s);
        dc_lq_ack_in  = 1'b1;
        dc_lq_data_in = data;
        step();                               // edge 3: ack sampled
        dc_lq_ack_in  = 1'b0;
        check("req_low_after_ack", lq_dc_req_out, 0);
        check("en_not_yet", lq_rob_en_out, 0);
        step();                               // edge 4: result pulse
        check("en_pulse", lq_rob_en_out, 1);
        check("result_dest", lq_rob_dest_out, tag);
        check("result_value", lq_rob_value_out, data);
        step();
        check("en_one_cycle", lq_rob_en_out, 0);
    endtask

    logic [3:0]  exp_tag;
    logic [31:0] exp_addr;

    initial begin
        checks              = 0;
        errors              = 0;
        rst_in              = 1'b0;
        rdy_in              = 1'b1;
        au_lq_valid_in      = 1'b0;
        au_lq_addr_in       = '0;
        au_lq_dest_in       = '0;
        au_lq_funct3_in     = '0;
        rob_lq_flush_in     = 1'b0;
        rob_lq_safe_en_in   = 1'b0;
        rob_lq_safe_dest_in = '0;
        dc_lq_ack_in        = 1'b0;
        dc_lq_data_in       = '0;
        exp_tag             = '0;
        exp_addr            = '0;

        // Reset state
        step();
        step();
        check("rst_ready", au_lq_ready_out, 1);
        check("rst_req", lq_dc_req_out, 0);
        check("rst_en", lq_rob_en_out, 0);
        check("rst_addr", lq_dc_addr_out, 0);
        check("rst_width", lq_dc_width_out, 0);
        check("rst_value", lq_rob_value_out, 0);
        rst_in = 1'b1;
        step();

        // LW 0x1000 tag 3, result at edge 4
        run_load(4'd3, 32'h0000_1000, 3'b010, 32'hDEAD_BEEF, 3'b100, 1'b0);

        // Fill DEPTH=4 without safe; fifth held until a retire
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", au_lq_ready_out, 1);
            au_lq_valid_in  = 1'b1;
            au_lq_addr_in   = 32'h100 + 32'(4 * i);
            au_lq_dest_in   = 4'(4 + i);
            au_lq_funct3_in = 3'b010;
            step();
        end
        check("full_ready", au_lq_ready_out, 0);
        au_lq_addr_in = 32'h110;
        au_lq_dest_in = 4'd8;
        step();
        check("full_hold_ready", au_lq_ready_out, 0);
        check("full_no_req", lq_dc_req_out, 0);
        rob_lq_safe_en_in   = 1'b1;
        rob_lq_safe_dest_in = 4'd4;
        step();
        rob_lq_safe_en_in   = 1'b0;
        check("full_after_safe", au_lq_ready_out, 0);
        step();
        check("head_issue_req", lq_dc_req_out, 1);
        check("head_issue_addr", lq_dc_addr_out, 32'h100);
        dc_lq_ack_in  = 1'b1;
        dc_lq_data_in = 32'h1122_3344;
        step();
        dc_lq_ack_in  = 1'b0;
        check("full_until_retire", au_lq_ready_out, 0);
        step();
        check("retire_en", lq_rob_en_out, 1);
        check("retire_dest", lq_rob_dest_out, 4);
        check("ready_after_retire", au_lq_ready_out, 1);
        step();                               // held fifth allocates now
        au_lq_valid_in = 1'b0;
        check("fifth_filled", au_lq_ready_out, 0);

        // Flush in the same cycle as ack
        rob_lq_safe_en_in   = 1'b1;
        rob_lq_safe_dest_in = 4'd5;
        step();
        rob_lq_safe_en_in   = 1'b0;
        step();
        check("flush_pre_req", lq_dc_req_out, 1);
        check("flush_pre_addr", lq_dc_addr_out, 32'h104);
        dc_lq_ack_in    = 1'b1;
        dc_lq_data_in   = 32'h0000_0099;
        rob_lq_flush_in = 1'b1;
        step();
        dc_lq_ack_in    = 1'b0;
        rob_lq_flush_in = 1'b0;
        check("flush_req", lq_dc_req_out, 0);
        check("flush_en", lq_rob_en_out, 0);
        check("flush_ready", au_lq_ready_out, 1);
        step();
        check("flush_en_next", lq_rob_en_out, 0);

        // Refill with tags 1, 2, 9, 10: exactly four fit after the flush
        for (int i = 0; i < 4; i++) begin
            check("refill_ready", au_lq_ready_out, 1);
            au_lq_valid_in  = 1'b1;
            au_lq_addr_in   = 32'h200 + 32'(4 * i);
            au_lq_dest_in   = (i == 0) ? 4'd1 : (i == 1) ? 4'd2 : 4'(7 + i);
            au_lq_funct3_in = 3'b010;
            step();
        end
        au_lq_valid_in = 1'b0;
        check("refill_full", au_lq_ready_out, 0);
        check("refill_no_req", lq_dc_req_out, 0);

        // Only tag 2 made safe
        rob_lq_safe_en_in   = 1'b1;
        rob_lq_safe_dest_in = 4'd2;
        step();
        rob_lq_safe_en_in   = 1'b0;
        step();
`ifdef LQ_OOO_EN
        check("ooo_req", lq_dc_req_out, 1);
        check("ooo_addr", lq_dc_addr_out, 32'h204);
        exp_tag  = 4'd2;
        exp_addr = 32'h204;
`else
        check("inorder_no_req", lq_dc_req_out, 0);
        step();
        check("inorder_still_no_req", lq_dc_req_out, 0);
        rob_lq_safe_en_in   = 1'b1;
        rob_lq_safe_dest_in = 4'd1;
        step();
        rob_lq_safe_en_in   = 1'b0;
        step();
        check("inorder_req", lq_dc_req_out, 1);
        check("inorder_addr", lq_dc_addr_out, 32'h200);
        exp_tag  = 4'd1;
        exp_addr = 32'h200;
`endif
        dc_lq_ack_in  = 1'b1;
        dc_lq_data_in = 32'h5A5A_5A5A;
        step();
        dc_lq_ack_in  = 1'b0;
        step();
        check("order_en", lq_rob_en_out, 1);
        check("order_dest", lq_rob_dest_out, exp_tag);
        check("order_value", lq_rob_value_out, 32'h5A5A_5A5A);
        rob_lq_flush_in = 1'b1;
        step();
        rob_lq_flush_in = 1'b0;
        check("flush2_req", lq_dc_req_out, 0);
        check("flush2_ready", au_lq_ready_out, 1);

        // Advance pointers to index 3, then LH / LBU across the wrap
        run_load(4'd13, 32'h300, 3'b010, 32'h0000_0013, 3'b100, 1'b0);
        run_load(4'd14, 32'h304, 3'b000, 32'hFFFF_FF80, 3'b001, 1'b1);
        run_load(4'd15, 32'h308, 3'b101, 32'h0000_8000, 3'b010, 1'b0);
        run_load(4'd11, 32'h2002, 3'b001, 32'hFFFF_8001, 3'b010, 1'b1);
        run_load(4'd12, 32'h2003, 3'b100, 32'h0000_00A5, 3'b001, 1'b0);

        // Full detection with wrapped pointers (head=5, tail 5 -> 1)
        for (int i = 0; i < 4; i++) begin
            check("wrap_fill_ready", au_lq_ready_out, 1);
            au_lq_valid_in  = 1'b1;
            au_lq_addr_in   = 32'h500 + 32'(4 * i);
            au_lq_dest_in   = 4'(i);
            au_lq_funct3_in = 3'b010;
            step();
        end
        au_lq_valid_in = 1'b0;
        check("wrap_full", au_lq_ready_out, 0);
        rob_lq_flush_in = 1'b1;
        step();
        rob_lq_flush_in = 1'b0;

        // Reset asserted while waiting for ack
        au_lq_valid_in      = 1'b1;
        au_lq_addr_in       = 32'h400;
        au_lq_dest_in       = 4'd7;
        au_lq_funct3_in     = 3'b010;
        rob_lq_safe_en_in   = 1'b1;
        rob_lq_safe_dest_in = 4'd7;
        step();
        au_lq_valid_in    = 1'b0;
        rob_lq_safe_en_in = 1'b0;
        step();
        check("wait_req", lq_dc_req_out, 1);
        rst_in = 1'b0;
        #1;
        check("async_rst_req", lq_dc_req_out, 0);
        check("async_rst_ready", au_lq_ready_out, 1);
        step();
        rst_in = 1'b1;
        step();
        step();
        check("post_rst_req", lq_dc_req_out, 0);
        check("post_rst_en", lq_rob_en_out, 0);
        check("post_rst_ready", au_lq_ready_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
